// File: rtl/idli_pkg.sv
// Shared types for the serial execution stage: decoded op, register indices,
// ALU/compare encodings and the compare-result helper.
package idli_pkg;

  typedef logic [2:0] greg_t;
  typedef logic [2:0] preg_t;

  localparam greg_t GREG_LR = 3'd7;

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR
  } alu_op_t;

  typedef enum logic [1:0] {
    LHS_SRC_REG,
    LHS_SRC_ZERO,
    LHS_SRC_PC
  } lhs_src_t;

  typedef enum logic {
    RHS_SRC_REG,
    RHS_SRC_IMM
  } rhs_src_t;

  typedef enum logic [2:0] {
    CMP_OP_EQ,
    CMP_OP_NE,
    CMP_OP_LT,
    CMP_OP_GE,
    CMP_OP_LTU,
    CMP_OP_GEU
  } cmp_op_t;

  // Everything the stage needs once the guarding predicate has been resolved.
  typedef struct packed {
    alu_op_t  alu_op;
    logic     alu_rhs_inv;
    logic     alu_cin;
    lhs_src_t lhs_src;
    rhs_src_t rhs_src;
    greg_t    a;
    logic     a_vld;
    greg_t    b;
    greg_t    c;
    logic     wr_lr;
    preg_t    q;
    logic     q_vld;
    cmp_op_t  cmp_op;
  } ex_t;

  typedef struct packed {
    preg_t p;
    ex_t   ex;
  } op_t;

  // Compares are lhs - rhs; cout is the inverted borrow, lt the signed less-than.
  function automatic logic cmp_eval(input cmp_op_t op, input logic zero,
                                    input logic cout, input logic lt);
    case (op)
      CMP_OP_EQ:  return zero;
      CMP_OP_NE:  return !zero;
      CMP_OP_LT:  return lt;
      CMP_OP_GE:  return !lt;
      CMP_OP_LTU: return !cout;
      CMP_OP_GEU: return cout;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/idli_sx_alu_m.sv
// Combinational beat ALU: one BEAT_W slice of add/and/or/xor with carry chain
// and the sign terms needed for a signed compare on the top beat.
module idli_sx_alu_m
  import idli_pkg::*;
#(
  parameter int BEAT_W = 4
) (
  input  alu_op_t           op,
  input  logic [BEAT_W-1:0] lhs,
  input  logic [BEAT_W-1:0] rhs,
  input  logic              rhs_inv,
  input  logic              cin,
  output logic [BEAT_W-1:0] out,
  output logic              cout,
  output logic              msb,
  output logic              ovf
);

  logic [BEAT_W-1:0] rhs_eff;
  logic [BEAT_W:0]   sum;

  assign rhs_eff = rhs_inv ? ~rhs : rhs;
  assign sum     = {1'b0, lhs} + {1'b0, rhs_eff} + {{BEAT_W{1'b0}}, cin};

  always_comb begin
    out  = sum[BEAT_W-1:0];
    cout = 1'b0;
    case (op)
      ALU_OP_ADD: cout = sum[BEAT_W];
      ALU_OP_AND: out  = lhs & rhs_eff;
      ALU_OP_OR:  out  = lhs | rhs_eff;
      ALU_OP_XOR: out  = lhs ^ rhs_eff;
      default:    out  = sum[BEAT_W-1:0];
    endcase
  end

  assign msb = out[BEAT_W-1];
  assign ovf = (lhs[BEAT_W-1] == rhs_eff[BEAT_W-1]) && (out[BEAT_W-1] != lhs[BEAT_W-1]);

endmodule

// File: rtl/idli_sx_ex_m.sv
// Serial execution stage: runs one decoded op over DATA_W/BEAT_W beats, LSB
// first, writing GPR beats or a predicate from a serial compare.
module idli_sx_ex_m
  import idli_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BEAT_W    = 4,
  parameter int NUM_PREDS = 8
) (
  input  logic              i_ex_gck,
  input  logic              i_ex_rst,
  input  op_t               i_ex_op,
  input  logic              i_ex_op_vld,
  output logic              o_ex_op_acp,
  input  logic              i_ex_stall,
  input  logic [BEAT_W-1:0] i_ex_imm,
  input  logic [BEAT_W-1:0] i_ex_pc,
  input  logic [BEAT_W-1:0] i_ex_pc_next,
  output greg_t             o_ex_lhs_reg,
  input  logic [BEAT_W-1:0] i_ex_lhs_data,
  output greg_t             o_ex_rhs_reg,
  input  logic [BEAT_W-1:0] i_ex_rhs_data,
  output greg_t             o_ex_wr_reg,
  output logic              o_ex_wr_en,
  output logic [BEAT_W-1:0] o_ex_wr_data,
  output logic              o_ex_done
);

  localparam int BEATS = DATA_W / BEAT_W;
  localparam int CTR_W = $clog2(BEATS);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BEATS - 1);

  ex_t                  op_q;
  logic                 op_vld_q;
  logic [CTR_W-1:0]     ctr_q;
  logic                 carry_q;
  logic                 zero_q;
  // The top predicate is hard-wired true, so only the lower entries are stored.
  logic [NUM_PREDS-2:0] pred_q;

  logic              adv;
  logic              last;
  logic              first;
  logic              acp;
  logic [BEAT_W-1:0] lhs;
  logic [BEAT_W-1:0] rhs;
  logic              cin;
  logic [BEAT_W-1:0] alu_out;
  logic              alu_cout;
  logic              alu_msb;
  logic              alu_ovf;
  logic              zero_nxt;
  logic              cmp_res;
  logic              pred_wr;
  logic              pred_rd;

  assign adv   = op_vld_q && !i_ex_stall;
  assign last  = op_vld_q && (ctr_q == CTR_LAST);
  assign first = (ctr_q == '0);
  assign acp   = !op_vld_q || (last && !i_ex_stall);

  always_comb begin
    lhs = '0;
    case (op_q.lhs_src)
      LHS_SRC_REG:  lhs = i_ex_lhs_data;
      LHS_SRC_ZERO: lhs = '0;
      LHS_SRC_PC:   lhs = i_ex_pc;
      default:      lhs = '0;
    endcase
  end

  assign rhs = (op_q.rhs_src == RHS_SRC_IMM) ? i_ex_imm : i_ex_rhs_data;
  assign cin = first ? op_q.alu_cin : carry_q;

  idli_sx_alu_m #(
    .BEAT_W (BEAT_W)
  ) u_alu (
    .op      (op_q.alu_op),
    .lhs     (lhs),
    .rhs     (rhs),
    .rhs_inv (op_q.alu_rhs_inv),
    .cin     (cin),
    .out     (alu_out),
    .cout    (alu_cout),
    .msb     (alu_msb),
    .ovf     (alu_ovf)
  );

  // On the last beat this is the all-zero flag of the whole word.
  assign zero_nxt = (first ? 1'b1 : zero_q) && (alu_out == '0);
  assign cmp_res  = cmp_eval(op_q.cmp_op, zero_nxt, alu_cout, alu_msb ^ alu_ovf);
  assign pred_wr  = last && adv && op_q.q_vld;

  // Predicate for the incoming op, forwarding a compare that retires this cycle.
  always_comb begin
    pred_rd = 1'b0;
    if (int'(i_ex_op.p) == NUM_PREDS - 1) begin
      pred_rd = 1'b1;
    end else if (int'(i_ex_op.p) < NUM_PREDS - 1) begin
      if (pred_wr && (op_q.q == i_ex_op.p)) pred_rd = cmp_res;
      else                                  pred_rd = pred_q[i_ex_op.p];
    end
  end

  always_ff @(posedge i_ex_gck) begin
    if (acp) op_q <= i_ex_op.ex;
  end

  always_ff @(posedge i_ex_gck) begin
    if (i_ex_rst) begin
      op_vld_q <= 1'b0;
      ctr_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      pred_q   <= '0;
    end else begin
      if (acp) op_vld_q <= i_ex_op_vld && pred_rd;
      if (adv) begin
        ctr_q   <= last ? '0 : ctr_q + 1'b1;
        carry_q <= alu_cout;
        zero_q  <= zero_nxt;
      end
      if (pred_wr && (int'(op_q.q) < NUM_PREDS - 1)) pred_q[op_q.q] <= cmp_res;
    end
  end

  assign o_ex_op_acp  = acp;
  assign o_ex_lhs_reg = op_q.b;
  assign o_ex_rhs_reg = op_q.c;
  assign o_ex_wr_en   = adv && (op_q.a_vld || op_q.wr_lr);
  assign o_ex_wr_reg  = op_q.wr_lr ? GREG_LR : op_q.a;
  assign o_ex_wr_data = op_q.wr_lr ? i_ex_pc_next : alu_out;
  assign o_ex_done    = last && !i_ex_stall;

endmodule

// File: tb/tb_idli_sx_ex_m.sv
// Directed bench for the serial execution stage: a 16/4 instance for most
// scenarios and a 32/8 instance for the wide-datapath checks.
module tb_idli_sx_ex_m;
  import idli_pkg::*;

  logic gck = 1'b0;
  logic rst = 1'b1;
  always #5 gck = ~gck;

  op_t        op;
  logic       op_vld, acp, stall, wr_en, done;
  logic [3:0] imm, pc, pc_next, lhs_data, rhs_data, wr_data;
  greg_t      lhs_reg, rhs_reg, wr_reg;

  op_t        w_op;
  logic       w_op_vld, w_acp, w_stall, w_wr_en, w_done;
  logic [7:0] w_imm, w_pc, w_pc_next, w_lhs_data, w_rhs_data, w_wr_data;
  greg_t      w_lhs_reg, w_rhs_reg, w_wr_reg;

  int n_chk  = 0;
  int n_fail = 0;

  idli_sx_ex_m #(.DATA_W(16), .BEAT_W(4), .NUM_PREDS(8)) u_dut (
    .i_ex_gck(gck), .i_ex_rst(rst), .i_ex_op(op), .i_ex_op_vld(op_vld),
    .o_ex_op_acp(acp), .i_ex_stall(stall), .i_ex_imm(imm), .i_ex_pc(pc),
    .i_ex_pc_next(pc_next), .o_ex_lhs_reg(lhs_reg), .i_ex_lhs_data(lhs_data),
    .o_ex_rhs_reg(rhs_reg), .i_ex_rhs_data(rhs_data), .o_ex_wr_reg(wr_reg),
    .o_ex_wr_en(wr_en), .o_ex_wr_data(wr_data), .o_ex_done(done)
  );

  idli_sx_ex_m #(.DATA_W(32), .BEAT_W(8), .NUM_PREDS(8)) u_dut_w (
    .i_ex_gck(gck), .i_ex_rst(rst), .i_ex_op(w_op), .i_ex_op_vld(w_op_vld),
    .o_ex_op_acp(w_acp), .i_ex_stall(w_stall), .i_ex_imm(w_imm), .i_ex_pc(w_pc),
    .i_ex_pc_next(w_pc_next), .o_ex_lhs_reg(w_lhs_reg), .i_ex_lhs_data(w_lhs_data),
    .o_ex_rhs_reg(w_rhs_reg), .i_ex_rhs_data(w_rhs_data), .o_ex_wr_reg(w_wr_reg),
    .o_ex_wr_en(w_wr_en), .o_ex_wr_data(w_wr_data), .o_ex_done(w_done)
  );

  function automatic op_t mk_add(input greg_t a, input lhs_src_t ls,
                                 input rhs_src_t rs, input preg_t p);
    op_t o = '0;
    o.p = p;
    o.ex.alu_op = ALU_OP_ADD;
    o.ex.lhs_src = ls;
    o.ex.rhs_src = rs;
    o.ex.a = a;
    o.ex.a_vld = 1'b1;
    o.ex.b = 3'd1;
    o.ex.c = 3'd2;
    return o;
  endfunction

  function automatic op_t mk_cmp(input cmp_op_t c, input preg_t q);
    op_t o = '0;
    o.p = 3'd7;
    o.ex.alu_op = ALU_OP_ADD;
    o.ex.alu_rhs_inv = 1'b1;
    o.ex.alu_cin = 1'b1;
    o.ex.lhs_src = LHS_SRC_REG;
    o.ex.rhs_src = RHS_SRC_REG;
    o.ex.q = q;
    o.ex.q_vld = 1'b1;
    o.ex.cmp_op = c;
    o.ex.b = 3'd1;
    o.ex.c = 3'd2;
    return o;
  endfunction

  task automatic test_reset();
    op_vld = 0; stall = 0; imm = 0; pc = 0; pc_next = 0; lhs_data = 0; rhs_data = 0;
    w_op_vld = 0; w_stall = 0; w_imm = 0; w_pc = 0; w_pc_next = 0; w_lhs_data = 0; w_rhs_data = 0;
    op = '0; w_op = '0; rst = 1;
    @(posedge gck);
    @(negedge gck); #1;
    n_chk++;
    if ({acp, wr_en, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_n16: acp/wr_en/done=%b expected 100", {acp, wr_en, done});
    end
    n_chk++;
    if ({w_acp, w_wr_en, w_done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_n32: acp/wr_en/done=%b expected 100", {w_acp, w_wr_en, w_done});
    end
    rst = 0;
  endtask

  // 0x0FFF + 0x0001: carry ripples through three beats into the top one.
  task automatic test_add();
    logic [15:0] l = 16'h0FFF, i = 16'h0001, e = 16'h1000;
    @(negedge gck); op = mk_add(3'd3, LHS_SRC_REG, RHS_SRC_IMM, 3'd7); op_vld = 1; #1;
    n_chk++;
    if (acp !== 1'b1) begin n_fail++; $display("FAIL add_issue_acp: got %b expected 1", acp); end
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); op_vld = 0; lhs_data = l[k*4+:4]; imm = i[k*4+:4]; #1;
      n_chk++;
      if ({wr_en, wr_reg, wr_data, done, acp} !== {1'b1, 3'd3, e[k*4+:4], k == 3, k == 3}) begin
        n_fail++;
        $display("FAIL add_beat%0d: wr_en/reg/data/done/acp=%b/%0d/%h/%b/%b expected 1/3/%h/%b/%b",
                 k, wr_en, wr_reg, wr_data, done, acp, e[k*4+:4], k == 3, k == 3);
      end
    end
    n_chk++;
    if ({lhs_reg, rhs_reg} !== {3'd1, 3'd2}) begin
      n_fail++; $display("FAIL add_rd_idx: lhs/rhs reg=%0d/%0d expected 1/2", lhs_reg, rhs_reg);
    end
  endtask

  // Runs a compare, then issues a probe op guarded by the written predicate in
  // the compare's final cycle; the probe executes only if the predicate is true.
  task automatic run_cmp(input string nm, input cmp_op_t c, input logic [15:0] l,
                         input logic [15:0] r, input preg_t q, input logic exp);
    @(negedge gck); op = mk_cmp(c, q); op_vld = 1; #1;
    n_chk++;
    if (acp !== 1'b1) begin n_fail++; $display("FAIL %s_issue_acp: got %b expected 1", nm, acp); end
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); lhs_data = l[k*4+:4]; rhs_data = r[k*4+:4];
      if (k == 3) begin op = mk_add(3'd4, LHS_SRC_ZERO, RHS_SRC_IMM, q); op_vld = 1; end
      else op_vld = 0;
      #1;
      n_chk++;
      if ({wr_en, done, acp} !== {1'b0, k == 3, k == 3}) begin
        n_fail++; $display("FAIL %s_beat%0d: wr_en/done/acp=%b expected %b", nm, k,
                           {wr_en, done, acp}, {1'b0, k == 3, k == 3});
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); op_vld = 0; imm = 4'h3; #1;
      n_chk++;
      if ({wr_en, done, acp} !== {exp, exp && k == 3, !exp || k == 3}) begin
        n_fail++; $display("FAIL %s_probe%0d: wr_en/done/acp=%b expected %b", nm, k,
                           {wr_en, done, acp}, {exp, exp && k == 3, !exp || k == 3});
      end
    end
  endtask

  task automatic test_cmp();
    run_cmp("ltu",     CMP_OP_LTU, 16'h0003, 16'h0005, 3'd2, 1'b1);
    run_cmp("eq_set",  CMP_OP_EQ,  16'h1200, 16'h1200, 3'd1, 1'b1);
    run_cmp("eq_clr",  CMP_OP_EQ,  16'h1200, 16'h1201, 3'd1, 1'b0);
    run_cmp("lt_sgn",  CMP_OP_LT,  16'h8000, 16'h0001, 3'd3, 1'b1);
    run_cmp("ne",      CMP_OP_NE,  16'h00F0, 16'h0F00, 3'd4, 1'b1);
    run_cmp("ltu_big", CMP_OP_LTU, 16'h8000, 16'h0001, 3'd4, 1'b0);
    run_cmp("ge_ovf",  CMP_OP_GE,  16'h0001, 16'h8000, 3'd6, 1'b1);
    run_cmp("geu",     CMP_OP_GEU, 16'h0005, 16'h0003, 3'd0, 1'b1);
    run_cmp("p_top",   CMP_OP_EQ,  16'h0001, 16'h0002, 3'd7, 1'b1);
  endtask

  // 0x1234 + 0x0F0F = 0x2143; stall three cycles on beat 2 and one on beat 3.
  task automatic test_stall();
    logic [15:0] e = 16'h2143, l = 16'h1234, r = 16'h0F0F;
    int   bt[8] = '{0, 1, 2, 2, 2, 2, 3, 3};
    logic st[8] = '{0, 0, 1, 1, 1, 0, 1, 0};
    op_t  o = mk_add(3'd2, LHS_SRC_REG, RHS_SRC_REG, 3'd7);
    @(negedge gck); op = o; op_vld = 1; #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge gck); op_vld = 0; stall = st[i];
      lhs_data = l[bt[i]*4+:4]; rhs_data = r[bt[i]*4+:4]; #1;
      n_chk++;
      if ({wr_en, wr_data, done, acp} !==
          {!st[i], e[bt[i]*4+:4], bt[i] == 3 && !st[i], bt[i] == 3 && !st[i]}) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: wr_en/data/done/acp=%b/%h/%b/%b expected %b/%h/%b/%b", i,
                 wr_en, wr_data, done, acp, !st[i], e[bt[i]*4+:4],
                 bt[i] == 3 && !st[i], bt[i] == 3 && !st[i]);
      end
    end
    stall = 0;
  endtask

  task automatic test_pred_false();
    @(negedge gck); op = mk_add(3'd3, LHS_SRC_ZERO, RHS_SRC_IMM, 3'd5); op_vld = 1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); op_vld = 0; imm = 4'h9; #1;
      n_chk++;
      if ({wr_en, done, acp} !== 3'b001) begin
        n_fail++; $display("FAIL pfalse_cyc%0d: wr_en/done/acp=%b expected 001", k, {wr_en, done, acp});
      end
    end
  endtask

  // PC operand (0x00FE + 2) followed back-to-back by a link write of pc_next.
  task automatic test_pc_link();
    logic [15:0] p = 16'h00FE, pn = 16'h0104, i = 16'h0002, e = 16'h0100;
    op_t o2 = mk_add(3'd6, LHS_SRC_ZERO, RHS_SRC_IMM, 3'd7);
    o2.ex.a_vld = 0; o2.ex.wr_lr = 1;
    @(negedge gck); op = mk_add(3'd5, LHS_SRC_PC, RHS_SRC_IMM, 3'd7); op_vld = 1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); pc = p[k*4+:4]; imm = i[k*4+:4];
      if (k == 3) begin op = o2; op_vld = 1; end else op_vld = 0;
      #1;
      n_chk++;
      if ({wr_en, wr_reg, wr_data} !== {1'b1, 3'd5, e[k*4+:4]}) begin
        n_fail++; $display("FAIL pc_beat%0d: wr_en/reg/data=%b/%0d/%h expected 1/5/%h", k,
                           wr_en, wr_reg, wr_data, e[k*4+:4]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); op_vld = 0; pc_next = pn[k*4+:4]; imm = 4'hF; #1;
      n_chk++;
      if ({wr_en, wr_reg, wr_data, done} !== {1'b1, GREG_LR, pn[k*4+:4], k == 3}) begin
        n_fail++; $display("FAIL link_beat%0d: wr_en/reg/data/done=%b/%0d/%h/%b expected 1/7/%h/%b",
                           k, wr_en, wr_reg, wr_data, done, pn[k*4+:4], k == 3);
      end
    end
  endtask

  // Reset on beat 1 of an op; predicates 2 and 6 were set by the compares.
  task automatic test_reset_mid();
    @(negedge gck); op = mk_add(3'd3, LHS_SRC_ZERO, RHS_SRC_IMM, 3'd7); op_vld = 1; #1;
    @(negedge gck); op_vld = 0; imm = 4'h1; #1;
    @(negedge gck); rst = 1; #1;
    @(negedge gck); rst = 0; #1;
    n_chk++;
    if ({wr_en, done, acp} !== 3'b001) begin
      n_fail++; $display("FAIL rst_mid: wr_en/done/acp=%b expected 001", {wr_en, done, acp});
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge gck); op = mk_add(3'd3, LHS_SRC_ZERO, RHS_SRC_IMM, (j == 0) ? 3'd2 : 3'd6);
      op_vld = 1; #1;
      @(negedge gck); op_vld = 0; #1;
      n_chk++;
      if ({wr_en, acp} !== 2'b01) begin
        n_fail++; $display("FAIL rst_pred_clr%0d: wr_en/acp=%b expected 01", j, {wr_en, acp});
      end
    end
    @(negedge gck); op = mk_add(3'd3, LHS_SRC_ZERO, RHS_SRC_IMM, 3'd7); op_vld = 1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); op_vld = 0; #1;
      n_chk++;
      if ({wr_en, done} !== {1'b1, k == 3}) begin
        n_fail++; $display("FAIL rst_pred_top%0d: wr_en/done=%b expected %b", k, {wr_en, done}, {1'b1, k == 3});
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] l = 32'hFFFF_FFFF, i = 32'h0000_0001, c = 32'h1234_5678;
    op_t o = mk_add(3'd3, LHS_SRC_REG, RHS_SRC_IMM, 3'd7);
    @(negedge gck); w_op = o; w_op_vld = 1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); w_op_vld = 0; w_lhs_data = l[k*8+:8]; w_imm = i[k*8+:8]; #1;
      n_chk++;
      if ({w_wr_en, w_wr_data, w_done} !== {1'b1, 8'h00, k == 3}) begin
        n_fail++; $display("FAIL wide_add%0d: wr_en/data/done=%b/%h/%b expected 1/00/%b", k,
                           w_wr_en, w_wr_data, w_done, k == 3);
      end
    end
    @(negedge gck); w_op = mk_cmp(CMP_OP_EQ, 3'd0); w_op_vld = 1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); w_lhs_data = c[k*8+:8]; w_rhs_data = c[k*8+:8];
      if (k == 3) begin w_op = mk_add(3'd4, LHS_SRC_ZERO, RHS_SRC_IMM, 3'd0); w_op_vld = 1; end
      else w_op_vld = 0;
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge gck); w_op_vld = 0; w_imm = 8'h11; #1;
      n_chk++;
      if ({w_wr_en, w_done} !== {1'b1, k == 3}) begin
        n_fail++; $display("FAIL wide_eq_probe%0d: wr_en/done=%b expected %b", k,
                           {w_wr_en, w_done}, {1'b1, k == 3});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_stall();
    test_pred_false();
    test_pc_link();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_sx_ex_m.md
Name: idli_sx_ex_m

Overview:
- Parametrised successor of the serial execution stage. Executes one decoded op over BEATS = DATA_W/BEAT_W cycles, LSB beat first.
- Adds:
  - generic datapath width;
  - an internal predicate file of configurable size;
  - serial compare ops that write predicates;
  - a real PC operand;
  - a stall input;
  - bypass of a predicate written on the final beat.
- Sits between decode and the external GPR file.

Parameters:
- DATA_W, 16: architectural word width; must be a multiple of BEAT_W.
- BEAT_W, 4: bits processed per cycle. BEATS = DATA_W/BEAT_W, BEATS >= 2.
- NUM_PREDS, 8: predicate registers. Index NUM_PREDS-1 always reads 1; writes to it are ignored.

Ports:
- i_ex_gck in 1: clock.
- i_ex_rst in 1: synchronous reset, active-high.
- i_ex_op in op_t: decoded op (fields listed under Decomposition).
- i_ex_op_vld in 1: op valid.
- o_ex_op_acp out 1: op accepted this cycle.
- i_ex_stall in 1: memory stall; freezes the current beat.
- i_ex_imm in BEAT_W: immediate beat.
- i_ex_pc in BEAT_W: current PC beat.
- i_ex_pc_next in BEAT_W: next PC beat.
- o_ex_lhs_reg out greg_t: GPR read index B.
- i_ex_lhs_data in BEAT_W: GPR read data for B.
- o_ex_rhs_reg out greg_t: GPR read index C.
- i_ex_rhs_data in BEAT_W: GPR read data for C.
- o_ex_wr_reg out greg_t: GPR write index.
- o_ex_wr_en out 1: GPR write enable.
- o_ex_wr_data out BEAT_W: GPR write beat.
- o_ex_done out 1: pulses on the last beat of a valid op.

Behaviour:
- State:
  - op_q, op_vld_q;
  - beat counter ctr_q, $clog2(BEATS) bits;
  - carry_q;
  - zero_q (running all-zero flag);
  - pred_q[NUM_PREDS].
- Reset (i_ex_rst sampled high at a clock edge):
  - op_vld_q=0, ctr_q=0, carry_q=0, zero_q=1;
  - all pred_q=0, except index NUM_PREDS-1, which reads as 1;
  - outputs: o_ex_op_acp=1, o_ex_wr_en=0, o_ex_done=0.
  - Reset mid-op abandons the op; no partial writes occur after the reset edge.
- Beat advance: adv = op_vld_q && !i_ex_stall. ctr_q increments on adv and wraps from BEATS-1 to 0. last = op_vld_q && ctr_q==BEATS-1.
- Accept: o_ex_op_acp = !op_vld_q || (last && !i_ex_stall).
- On accept:
  - op_q <= i_ex_op;
  - op_vld_q <= i_ex_op_vld && pred_rd(i_ex_op.p).
  - Ops with a false predicate are dropped and never produce writes or done.
- Predicate read bypass: if the current cycle writes predicate i_ex_op.p (last beat of a compare), pred_rd returns the new value, not pred_q.
- Operand select:
  - LHS: REG gives i_ex_lhs_data; ZERO gives 0; PC gives i_ex_pc.
  - RHS: REG gives i_ex_rhs_data; IMM gives i_ex_imm.
  - The RHS beat is inverted when alu_rhs_inv=1.
- ALU per beat:
  - ADD: BEAT_W-bit sum with carry out.
  - AND, OR, XOR: carry out 0.
  - cin = (ctr_q==0) ? op_q.alu_cin : carry_q.
  - carry_q and zero_q update only on adv.
  - zero_q <= (ctr_q==0 ? 1 : zero_q) && (alu_out==0).
- GPR write:
  - o_ex_wr_en = adv && (a_vld || wr_lr).
  - reg = wr_lr ? GREG_LR : a.
  - data = wr_lr ? i_ex_pc_next : alu_out.
  - Write enable is low while stalled.
- Compare (q_vld=1): the op is a subtract (decode sets rhs_inv=1, cin=1). On last && adv, pred[q] <= result:
  - EQ: zero_final.
  - NE: !zero_final.
  - LTU: !cout.
  - GEU: cout.
  - LT: msb_out ^ ovf, where ovf = (lhs_msb == rhs_inv_msb) && (msb_out != lhs_msb).
  - GE: !LT.
  - zero_final = zero_q && (alu_out==0). When BEATS... ctr_q>0 on last beat, so zero_final combines the running flag with the final beat.
- Done: o_ex_done = last && !i_ex_stall.
- Back-to-back ops: a new op may be accepted in the same cycle as the previous op's done, giving no bubble.
- Stall on the last beat: acp=0 and done=0 until the stall drops.

Decomposition:
- idli_pkg:
  - op_t gains cmp_op (cmp_op_t: EQ, NE, LT, GE, LTU, GEU);
  - lhs_src_t gains a live LHS_SRC_PC;
  - greg_t, preg_t, GREG_LR, alu_op_t.
- Sub-module: idli_sx_alu_m. A BEAT_W-parametrised combinational beat ALU producing out, cout and msb/overflow terms.
- The predicate file stays inline, since it needs the bypass.

Test Plan:
- DATA_W=16, BEAT_W=4, no stall. ADD r1=0x0FFF + imm 0x0001 -> wr_en for 4 beats. wr_data 0,0,0,1 (LSB first). done on cycle 4. acp=1 on cycle 4.
- Compare LTU with lhs 0x0003, rhs 0x0005, q=2 -> pred[2]=1 after the last beat. The next op with p=2 is accepted in the same cycle and executes (bypass).
- Compare EQ with 0x1200 vs 0x1201 -> pred=0. LT with 0x8000 vs 0x0001 -> pred=1 (signed).
- Stall asserted on beat 2 for 3 cycles -> ctr_q holds, wr_en=0 during the stall. Final result is identical to the unstalled run. done is delayed 3 cycles.
- Op whose predicate is false -> op_vld_q=0, no writes, no done, acp stays 1. Reset asserted mid-op on beat 1 -> next cycle wr_en=0, acp=1, all preds 0 except P[NUM_PREDS-1].
- DATA_W=32, BEAT_W=8: ADD 0xFFFFFFFF+1 -> four zero beats. EQ compare on equal operands -> pred=1.
